// File: rtl/unsaved_leds_if.sv
// rtl/unsaved_leds_if.sv - Avalon-MM s1 slave bus bundle for the LED output port
interface unsaved_leds_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/unsaved_leds.sv
// rtl/unsaved_leds.sv - LED output port with set/clear aliases and prescaled per-bit blink
module unsaved_leds #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic             clk,
  input  logic             reset_n,
  unsaved_leds_if.slave    bus,
  output logic [WIDTH-1:0] out_port
);

  localparam int unsigned      CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [WIDTH-1:0] DATA_RST = RESET_VALUE[WIDTH-1:0];

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_BLINK    = 2'd1;
  localparam logic [1:0] ADDR_OUTSET   = 2'd2;
  localparam logic [1:0] ADDR_OUTCLEAR = 2'd3;

  logic [WIDTH-1:0] data_q,  data_d;
  logic [WIDTH-1:0] blink_q, blink_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             phase_q, phase_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic [31:0]      rd_q,    rd_d;

  logic             wr;
  logic [WIDTH-1:0] wval;
  logic             unused_wdata;

  assign wr   = bus.chipselect & ~bus.write_n;
  assign wval = bus.writedata[WIDTH-1:0];

  // Bits of writedata above WIDTH are deliberately discarded.
  assign unused_wdata = ^bus.writedata;

  // Data register: plain write plus atomic set/clear aliases.
  always_comb begin
    data_d = data_q;
    if (wr) begin
      case (bus.address)
        ADDR_DATA:     data_d = wval;
        ADDR_OUTSET:   data_d = data_q | wval;
        ADDR_OUTCLEAR: data_d = data_q & ~wval;
        default:       data_d = data_q;
      endcase
    end
  end

  // Blink mask register.
  always_comb begin
    blink_d = blink_q;
    if (wr && (bus.address == ADDR_BLINK)) begin
      blink_d = wval;
    end
  end

  // Prescaler: runs only while blinking; clearing the mask beats a same-cycle toggle.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (blink_d == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (blink_q != '0) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Pin drive: blinking bits are dark during phase 1.
  always_comb begin
    out_d = data_q & ~(blink_q & {WIDTH{phase_q}});
  end

  // Read mux, sampled every cycle regardless of chipselect.
  always_comb begin
    rd_d = '0;
    case (bus.address)
      ADDR_DATA:     rd_d[WIDTH-1:0] = data_q;
      ADDR_BLINK:    rd_d[WIDTH-1:0] = blink_q;
      ADDR_OUTSET:   rd_d = '0;
      ADDR_OUTCLEAR: rd_d[0] = phase_q;
      default:       rd_d = '0;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= DATA_RST;
      blink_q <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      out_q   <= DATA_RST;
      rd_q    <= '0;
    end else begin
      data_q  <= data_d;
      blink_q <= blink_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      out_q   <= out_d;
      rd_q    <= rd_d;
    end
  end

  assign out_port     = out_q;
  assign bus.readdata = rd_q;

endmodule

// File: tb/tb_unsaved_leds.sv
// tb/tb_unsaved_leds.sv - directed scoreboard bench for unsaved_leds
module tb_unsaved_leds;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] out_port;

  always #5 clk = ~clk;

  unsaved_leds_if bus ();

  unsaved_leds #(
    .WIDTH(8),
    .RESET_VALUE(32'h0),
    .BLINK_DIV(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .out_port(out_port)
  );

  typedef struct {
    string       tag;
    logic        sel;
    logic [31:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic push_rd(input string tag, input logic [31:0] e);
    sbq.push_back('{tag, 1'b0, e});
  endtask

  task automatic push_out(input string tag, input logic [7:0] e);
    sbq.push_back('{tag, 1'b1, {24'b0, e}});
  endtask

  task automatic drain();
    sb_t         e;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = e.sel ? {24'b0, out_port} : bus.readdata;
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [1:0] a);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = a;
  endtask

  task automatic wr_setup(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
  endtask

  // k counts edges after the one that enabled blinking; optional DATA write at tick wr_k.
  task automatic blink_run(input int n, input int wr_k, input logic [7:0] d0,
                           input logic [7:0] d1, input logic [7:0] bl);
    int         j;
    logic [7:0] ph;
    logic [7:0] dj;
    for (int k = 1; k <= n; k++) begin
      j  = k - 1;
      ph = ((j / 4) % 2 == 1) ? 8'hFF : 8'h00;
      dj = (wr_k > 0 && j >= wr_k) ? d1 : d0;
      if (k == wr_k) begin
        wr_setup(2'd0, {24'b0, d1});
        push_rd("blink_rd_data", {24'b0, dj});
      end else begin
        idle(2'd3);
        push_rd("blink_phase", {31'b0, ph[0]});
      end
      push_out("blink_out", dj & ~(bl & ph));
      tick();
      drain();
    end
    idle(2'd3);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.writedata = '0;
    idle(2'd0);
    repeat (3) tick();
    push_rd("rst_rd", 32'h0);
    push_out("rst_out", 8'h00);
    drain();
    reset_n = 1'b1;

    for (int a = 0; a < 4; a++) begin
      idle(2'(a));
      push_rd("rst_read_addr", 32'h0);
      push_out("rst_out_idle", 8'h00);
      tick();
      drain();
    end

    wr_setup(2'd0, 32'hFFFF_FFA5);
    push_out("wr_pin_latency", 8'h00);
    tick();
    drain();
    idle(2'd0);
    push_out("data_pin", 8'hA5);
    push_rd("rd_data", 32'h0000_00A5);
    tick();
    drain();

    wr_setup(2'd2, 32'h0000_000A);
    tick();
    idle(2'd2);
    push_out("outset_pin", 8'hAF);
    push_rd("rd_outset", 32'h0);
    tick();
    drain();

    wr_setup(2'd3, 32'h0000_0021);
    tick();
    idle(2'd1);
    push_out("outclear_pin", 8'h8E);
    push_rd("rd_blink_zero", 32'h0);
    tick();
    drain();

    wr_setup(2'd0, 32'h0000_00FF);
    tick();
    idle(2'd0);
    push_rd("raw_data", 32'h0000_00FF);
    push_out("raw_pin", 8'hFF);
    tick();
    drain();

    wr_setup(2'd1, 32'h1234_560F);
    tick();
    blink_run(12, 0, 8'hFF, 8'hFF, 8'h0F);

    wr_setup(2'd1, 32'h0);
    push_out("clr_pin_now", 8'hF0);
    tick();
    drain();
    idle(2'd3);
    push_rd("clr_phase", 32'h0);
    push_out("clr_pin", 8'hFF);
    tick();
    drain();
    for (int i = 0; i < 5; i++) begin
      push_rd("clr_phase_hold", 32'h0);
      push_out("clr_pin_hold", 8'hFF);
      tick();
      drain();
    end

    wr_setup(2'd1, 32'h0000_000F);
    tick();
    idle(2'd3);
    for (int i = 0; i < 3; i++) begin
      push_rd("tc_pre_phase", 32'h0);
      push_out("tc_pre_pin", 8'hFF);
      tick();
      drain();
    end
    wr_setup(2'd1, 32'h0);
    push_out("tc_clr_pin", 8'hFF);
    tick();
    drain();
    idle(2'd3);
    for (int i = 0; i < 6; i++) begin
      push_rd("tc_phase", 32'h0);
      push_out("tc_no_glitch", 8'hFF);
      tick();
      drain();
    end

    wr_setup(2'd1, 32'h0000_000F);
    tick();
    blink_run(14, 6, 8'hFF, 8'h3C, 8'h0F);

    idle(2'd0);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    push_rd("async_rd", 32'h0);
    push_out("async_pin", 8'h00);
    drain();
    tick();
    reset_n = 1'b1;
    idle(2'd1);
    push_rd("post_rst_blink", 32'h0);
    push_out("post_rst_pin", 8'h00);
    tick();
    drain();
    idle(2'd3);
    push_rd("post_rst_phase", 32'h0);
    tick();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
